// File: rtl/sha_round_engine.sv
// SHA-256 compression engine applying RPC (1, 2 or 4) rounds per clock.
// Define SHA224_EN to add the SHA-224 IV and DIGEST[31:0] truncation under MODE224.
module sha_round_engine #(
  parameter int unsigned RPC = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic         init_i,
  input  logic         mode224_i,
  input  logic [511:0] block_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [255:0] digest_o
);

  if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
    $error("sha_round_engine: RPC must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] Iv256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic        done_q, done_d;
  logic        init_q, init_d;

  logic [31:0] iv_load [8];
  logic [31:0] iv_fin [8];
  logic        trunc;
  logic        last_round;

`ifdef SHA224_EN
  localparam logic [31:0] Iv224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  logic mode_q, mode_d;

  assign mode_d = (state_q == StIdle && start_i) ? mode224_i : mode_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) mode_q <= 1'b0;
    else           mode_q <= mode_d;
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv_load[i] = mode224_i ? Iv224[i] : Iv256[i];
      iv_fin[i]  = mode_q ? Iv224[i] : Iv256[i];
    end
  end

  assign trunc = mode_q;
`else
  logic unused_mode224;
  assign unused_mode224 = mode224_i;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv_load[i] = Iv256[i];
      iv_fin[i]  = Iv256[i];
    end
  end

  assign trunc = 1'b0;
`endif

  assign last_round = (cnt_q == 6'(64 - RPC));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRound;
      StRound: if (last_round) state_d = StFinal;
      StFinal: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RPC rounds chained combinationally; the window always produces W[t+16] and shifts.
  logic [31:0] rv [8];
  logic [31:0] rw [16];

  always_comb begin
    logic [31:0] t1, t2, nw;
    t1 = '0;
    t2 = '0;
    nw = '0;
    rv = v_q;
    rw = w_q;
    for (int unsigned j = 0; j < RPC; j++) begin
      t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
           + K[cnt_q + 6'(j)] + rw[0];
      t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      nw = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
      rv[7] = rv[6];
      rv[6] = rv[5];
      rv[5] = rv[4];
      rv[4] = rv[3] + t1;
      rv[3] = rv[2];
      rv[2] = rv[1];
      rv[1] = rv[0];
      rv[0] = t1 + t2;
      for (int i = 0; i < 15; i++) rw[i] = rw[i + 1];
      rw[15] = nw;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    v_d    = v_q;
    w_d    = w_q;
    h_d    = h_q;
    done_d = 1'b0;
    init_d = init_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          init_d = init_i;
          cnt_d  = '0;
          for (int i = 0; i < 16; i++) w_d[i] = block_in_i[511 - 32 * i -: 32];
          for (int i = 0; i < 8; i++) v_d[i] = init_i ? iv_load[i] : h_q[i];
        end
      end
      StRound: begin
        v_d   = rv;
        w_d   = rw;
        cnt_d = cnt_q + 6'(RPC);
      end
      StFinal: begin
        done_d = 1'b1;
        // DIGEST is frozen while busy, so it still holds the chaining value here.
        for (int i = 0; i < 8; i++) h_d[i] = (init_q ? iv_fin[i] : h_q[i]) + v_q[i];
        if (trunc) h_d[7] = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= Iv256[i];
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      init_q  <= init_d;
      v_q     <= v_d;
      w_q     <= w_d;
      h_q     <= h_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

  always_comb begin
    for (int i = 0; i < 8; i++) digest_o[255 - 32 * i -: 32] = h_q[i];
  end

endmodule

// File: tb/tb_sha_round_engine.sv
// Bench for sha_round_engine: RPC=1/2/4 instances against a plain SHA-256 reference model.
module tb_sha_round_engine;

`ifdef SHA224_EN
  localparam bit Sha224On = 1'b1;
`else
  localparam bit Sha224On = 1'b0;
`endif

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] HELLO_DIG =
    256'hc0535e4be2b79ffd93291305436bf889314e4a3faec05ecffcbb7df31ad9e51a;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [223:0] ABC224_DIG =
    224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] HELLO_BLK = {32'h48656c6c, 32'h6f20776f, 32'h726c6421,
                                        32'h80000000, {11{32'h0}}, 32'h00000060};
  localparam logic [511:0] TWO_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
  localparam logic [511:0] TWO_BLK2 = {{15{32'h0}}, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   start_v;
  logic         init;
  logic         mode224;
  logic [511:0] block_in;
  logic [2:0]   busy_w;
  logic [2:0]   done_w;
  logic [255:0] digest_w [3];

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] h_ref [3];

  always #5 clk = ~clk;

  sha_round_engine #(.RPC(1)) u_r1 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_v[0]), .init_i(init), .mode224_i(mode224),
    .block_in_i(block_in), .busy_o(busy_w[0]), .done_o(done_w[0]), .digest_o(digest_w[0])
  );
  sha_round_engine #(.RPC(2)) u_r2 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_v[1]), .init_i(init), .mode224_i(mode224),
    .block_in_i(block_in), .busy_o(busy_w[1]), .done_o(done_w[1]), .digest_o(digest_w[1])
  );
  sha_round_engine #(.RPC(4)) u_r4 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_v[2]), .init_i(init), .mode224_i(mode224),
    .block_in_i(block_in), .busy_o(busy_w[2]), .done_o(done_w[2]), .digest_o(digest_w[2])
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression with a full 64-word message schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) hv[i] = hin[255 - 32 * i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  task automatic model_step(input int k, input logic [511:0] blk, input logic ini,
                            input logic m, output logic [255:0] exp);
    logic [255:0] chain;
    chain = ini ? ((m && Sha224On) ? IV224 : IV256) : h_ref[k];
    exp = compress(chain, blk);
    if (m && Sha224On) exp[31:0] = '0;
    h_ref[k] = exp;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[511 - 32 * i -: 32] = $urandom();
    return blk;
  endfunction

  // Caller is just past a rising edge (or at a reset release); START is sampled at the next edge.
  task automatic run_one(input int k, input logic [511:0] blk, input logic ini, input logic m,
                         input bit hold, output int lat, output logic [255:0] dig,
                         output bit busy_ok);
    lat = -1;
    dig = '0;
    busy_ok = 1'b1;
    block_in = blk;
    init = ini;
    mode224 = m;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_v[k] = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (hold) block_in = rand_block();
      @(posedge clk); #1;
      if (done_w[k]) begin
        lat = n;
        dig = digest_w[k];
        if (busy_w[k]) busy_ok = 1'b0;
        break;
      end
      if (!busy_w[k]) busy_ok = 1'b0;
    end
    start_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d]: busy=%b done=%b, want 0 0", k, busy_w[k], done_w[k]);
      end
      vectors++;
      if (digest_w[k] !== IV256) begin
        miscompares++;
        $display("FAIL reset_digest[%0d]: got %h want %h", k, digest_w[k], IV256);
      end
    end
  endtask

  task automatic test_chain_from_reset();
    int lat; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, ABC_BLK, 1'b0, 1'b0, exp);
      run_one(k, ABC_BLK, 1'b0, 1'b0, 1'b0, lat, dig, bok);
      vectors++;
      if (dig !== ABC_DIG || lat !== 64 / (1 << k) + 1) begin
        miscompares++;
        $display("FAIL chain_reset[%0d]: got %h lat %0d want %h lat %0d",
                 k, dig, lat, ABC_DIG, 64 / (1 << k) + 1);
      end
    end
  endtask

  task automatic test_hello();
    int lat; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, HELLO_BLK, 1'b1, 1'b0, exp);
      run_one(k, HELLO_BLK, 1'b1, 1'b0, 1'b0, lat, dig, bok);
      vectors++;
      if (dig !== HELLO_DIG || lat !== 64 / (1 << k) + 1 || !bok) begin
        miscompares++;
        $display("FAIL hello[%0d]: got %h lat %0d busy_ok %0d want %h lat %0d busy_ok 1",
                 k, dig, lat, bok, HELLO_DIG, 64 / (1 << k) + 1);
      end
    end
  endtask

  task automatic test_abc_rpc();
    int lat; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, ABC_BLK, 1'b1, 1'b0, exp);
      run_one(k, ABC_BLK, 1'b1, 1'b0, 1'b0, lat, dig, bok);
      vectors++;
      if (lat !== 64 / (1 << k) + 1) begin
        miscompares++;
        $display("FAIL abc_latency[%0d]: got %0d want %0d", k, lat, 64 / (1 << k) + 1);
      end
      vectors++;
      if (dig !== ABC_DIG || !bok) begin
        miscompares++;
        $display("FAIL abc_digest[%0d]: got %h busy_ok %0d want %h busy_ok 1",
                 k, dig, bok, ABC_DIG);
      end
    end
  endtask

  task automatic test_two_block();
    int lat1, lat2; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, TWO_BLK1, 1'b1, 1'b0, exp);
      run_one(k, TWO_BLK1, 1'b1, 1'b0, 1'b0, lat1, dig, bok);
      model_step(k, TWO_BLK2, 1'b0, 1'b0, exp);
      run_one(k, TWO_BLK2, 1'b0, 1'b0, 1'b0, lat2, dig, bok);
      vectors++;
      if (dig !== TWO_DIG || lat2 !== 64 / (1 << k) + 1) begin
        miscompares++;
        $display("FAIL two_block[%0d]: got %h lat %0d want %h lat %0d",
                 k, dig, lat2, TWO_DIG, 64 / (1 << k) + 1);
      end
    end
  endtask

  task automatic test_mode224();
    int lat; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, ABC_BLK, 1'b1, 1'b1, exp);
      run_one(k, ABC_BLK, 1'b1, 1'b1, 1'b0, lat, dig, bok);
`ifdef SHA224_EN
      vectors++;
      if (dig[255:32] !== ABC224_DIG || dig[31:0] !== 32'h0) begin
        miscompares++;
        $display("FAIL sha224[%0d]: got %h want %h00000000", k, dig, ABC224_DIG);
      end
`else
      vectors++;
      if (dig !== ABC_DIG) begin
        miscompares++;
        $display("FAIL mode224_ignored[%0d]: got %h want %h", k, dig, ABC_DIG);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int lat, dones; logic [255:0] dig, exp; bit bok;
    for (int k = 0; k < 3; k++) begin
      model_step(k, ABC_BLK, 1'b1, 1'b0, exp);
      run_one(k, ABC_BLK, 1'b1, 1'b0, 1'b1, lat, dig, bok);
      vectors++;
      if (dig !== ABC_DIG || lat !== 64 / (1 << k) + 1) begin
        miscompares++;
        $display("FAIL hold_start[%0d]: got %h lat %0d want %h lat %0d",
                 k, dig, lat, ABC_DIG, 64 / (1 << k) + 1);
      end
      dones = 0;
      for (int n = 0; n < 4; n++) begin
        block_in = rand_block();
        @(posedge clk); #1;
        if (done_w[k] || busy_w[k]) dones++;
      end
      vectors++;
      if (dones !== 0 || digest_w[k] !== ABC_DIG) begin
        miscompares++;
        $display("FAIL hold_after[%0d]: extra activity %0d digest %h want 0 %h",
                 k, dones, digest_w[k], ABC_DIG);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit seen, bok; logic [255:0] dig, exp;
    for (int k = 0; k < 3; k++) begin
      block_in = ABC_BLK;
      init = 1'b1;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 30 / (1 << k); n++) begin
        @(posedge clk); #1;
        if (done_w[k]) seen = 1'b1;
      end
      vectors++;
      if (seen !== 1'b0 || busy_w[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_pre[%0d]: done_seen=%0d busy=%b want 0 1", k, seen, busy_w[k]);
      end
      reset_n = 1'b0;
      #2;
      vectors++;
      if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || digest_w[k] !== IV256) begin
        miscompares++;
        $display("FAIL abort_reset[%0d]: busy=%b done=%b digest %h want 0 0 %h",
                 k, busy_w[k], done_w[k], digest_w[k], IV256);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 3; j++) h_ref[j] = IV256;
      model_step(k, ABC_BLK, 1'b1, 1'b0, exp);
      run_one(k, ABC_BLK, 1'b1, 1'b0, 1'b0, lat, dig, bok);
      vectors++;
      if (dig !== ABC_DIG || lat !== 64 / (1 << k) + 1) begin
        miscompares++;
        $display("FAIL abort_restart[%0d]: got %h lat %0d want %h lat %0d",
                 k, dig, lat, ABC_DIG, 64 / (1 << k) + 1);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit bok; logic [255:0] dig, exp; logic [511:0] blk; logic ini, m;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        blk = rand_block();
        ini = 1'($urandom_range(0, 1));
        m = 1'($urandom_range(0, 1));
        model_step(k, blk, ini, m, exp);
        run_one(k, blk, ini, m, 1'b0, lat, dig, bok);
        vectors++;
        if (dig !== exp || lat !== 64 / (1 << k) + 1 || !bok) begin
          miscompares++;
          $display("FAIL random[%0d,%0d]: got %h lat %0d busy_ok %0d want %h lat %0d busy_ok 1",
                   r, k, dig, lat, bok, exp, 64 / (1 << k) + 1);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_v = '0;
    init = 1'b0;
    mode224 = 1'b0;
    block_in = '0;
    for (int j = 0; j < 3; j++) h_ref[j] = IV256;
    #22;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_chain_from_reset();
    test_hello();
    test_abc_rpc();
    test_two_block();
    test_mode224();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_round_engine.md
SHA_ROUND_ENGINE -- requirements
Module: sha_round_engine

Interface
REQ-001 The block SHALL have parameter RPC, default 1, setting SHA-256 rounds executed per clock; legal values are 1, 2 and 4.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit: request to compress BLOCK_IN, sampled only in IDLE.
REQ-005 The block SHALL have port INIT, input, 1 bit, sampled with START: 1 selects the IV as chaining input, 0 selects the held digest.
REQ-006 The block SHALL have port MODE224, input, 1 bit, sampled with START: selects the SHA-224 IV and truncation.
REQ-007 The block SHALL have port BLOCK_IN, input, 512 bits: padded message block, word W0 at bits [511:480], big-endian words.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high in states ROUND and FINAL.
REQ-009 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when DIGEST updates.
REQ-010 The block SHALL have port DIGEST, output, 256 bits: H0 at [255:224] through H7 at [31:0].

Function
REQ-011 The state machine SHALL have three states, IDLE, ROUND and FINAL; transitions are IDLE->ROUND on START, ROUND->FINAL when the round counter completes round 63, and FINAL->IDLE unconditionally.
REQ-012 On START in IDLE, the block SHALL load the 16-word schedule window from BLOCK_IN, load a..h from the chaining input, latch MODE224, and clear the 6-bit round counter.
REQ-013 In ROUND, each cycle SHALL apply RPC rounds (t..t+RPC-1) with K[t] taken from an internal 64-entry ROM and W[t] generated by the sliding window (sigma0/sigma1 from t=16 on); the counter advances by RPC.
REQ-014 All additions SHALL be modulo 2^32.
REQ-015 In FINAL, each Hi SHALL be set to chaining input + working variable, and DONE SHALL be asserted for exactly that cycle.
REQ-016 Latency SHALL be 64/RPC+1 rising edges from the edge sampling START to the edge that asserts DONE.
REQ-017 The next START SHALL be accepted in the cycle after DONE.
REQ-018 START while BUSY SHALL be ignored, with no queuing.
REQ-019 DIGEST SHALL hold its value between DONE pulses, and changes to BLOCK_IN during BUSY SHALL have no effect.
REQ-020 INIT=0 with no prior completed block SHALL chain from the reset value of DIGEST.
REQ-021 If RPC is not 1, 2 or 4, the block SHALL stop elaboration with an error.

Reset
REQ-022 While RESET_N is low, the block SHALL be in IDLE with BUSY=0, DONE=0, round counter 0, working variables 0, and DIGEST equal to the SHA-256 IV (6a09e667 ... 5be0cd19).
REQ-023 Reset asserted mid-operation SHALL abort the block immediately; no DONE is produced and the partial result is discarded.
REQ-024 After RESET_N rises, the first START SHALL be accepted on the first rising edge.

Configuration
REQ-025 With macro SHA224_EN defined, MODE224=1 SHALL select the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4) when INIT=1, and SHALL drive DIGEST[31:0] to 0 at DONE.
REQ-026 With macro SHA224_EN undefined, MODE224 SHALL be ignored and the block SHALL operate as pure SHA-256, with no SHA-224 IV ROM present.

Verification
REQ-027 The bench SHALL cover: "Hello world!" padded block, INIT=1, RPC=1 -> DONE at edge 65, DIGEST=c0535e4be2b79ffd93291305436bf889314e4a3faec05ecffcbb7df31ad9e51a.
REQ-028 The bench SHALL cover: "abc" block at RPC=1, 2 and 4 -> DIGEST=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with DONE at edge 65, 33 and 17 respectively.
REQ-029 The bench SHALL cover: the two-block 448-bit "abcdbcdecdef...nopq" message, block 1 with INIT=1 and block 2 with INIT=0 started the cycle after DONE -> DIGEST=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-030 The bench SHALL cover: SHA224_EN defined, "abc" block, MODE224=1 -> DIGEST[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 and DIGEST[31:0]=0.
REQ-031 The bench SHALL cover: RESET_N pulsed low at round 30, then "abc" started again -> no DONE for the aborted block, and the second result matches REQ-028.
REQ-032 The bench SHALL cover: START held high and BLOCK_IN changed throughout BUSY -> exactly one DONE and an unchanged "abc" digest.
